// File: rtl/bcd_addsub_serial_if.sv
// Handshake and data bundle for bcd_addsub_serial.
// master: drives start/mode/cin/a/b and observes the result side.
// slave : the arithmetic unit; drives busy/done/result/cout/neg/err.
interface bcd_addsub_serial_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  start;
  logic                  mode;
  logic                  cin;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   result;
  logic                  cout;
  logic                  neg;
  logic                  err;

  modport master (
    output start, mode, cin, a, b,
    input  busy, done, result, cout, neg, err
  );

  modport slave (
    input  start, mode, cin, a, b,
    output busy, done, result, cout, neg, err
  );
endinterface

// File: rtl/bcd_addsub_serial.sv
// Digit-serial N-digit BCD adder/subtractor, LSD first, one shared digit adder.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - bcd_addsub_serial_if.slave: start/mode/cin/a/b in,
//           busy/done/result/cout/neg/err out
// Optional feature: define BCD_ADDSUB_SIGN_MAG_EN to return |A - B - cin| with neg
// set when a subtraction borrows (adds a FIX pass of DIGITS cycles).
module bcd_addsub_serial #(
  parameter int unsigned DIGITS = 4
) (
  input logic               clk,
  input logic               rst_n,
  bcd_addsub_serial_if.slave bus
);

  localparam int unsigned W    = 4 * DIGITS;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e          state_q;
  logic [W-1:0]    a_q, b_q, work_q, result_q;
  logic            mode_q, carry_q, err_pend_q;
  logic [IdxW-1:0] idx_q;
  logic            busy_q, done_q, cout_q, err_q, neg_q;

  logic [3:0]   dig_a, dig_b, dig_sum;
  logic [4:0]   sum;
  logic         c_next;
  logic [W-1:0] work_next;
  logic         err_in;

  // Any non-decimal digit in the presented operands.
  always_comb begin
    err_in = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bus.a[4*i +: 4] > 4'd9) err_in = 1'b1;
      if (bus.b[4*i +: 4] > 4'd9) err_in = 1'b1;
    end
  end

  // Shared digit adder. Operands are shifted right each step, so the current
  // digit always sits in [3:0]; results enter the working register from the top.
  always_comb begin
    dig_a = a_q[3:0];
    dig_b = mode_q ? (4'd9 - b_q[3:0]) : b_q[3:0];
`ifdef BCD_ADDSUB_SIGN_MAG_EN
    // FIX pass: nine's complement of the working digit, +1 via carry_q on digit 0.
    if (state_q == StFix) begin
      dig_a = 4'd9 - work_q[3:0];
      dig_b = 4'd0;
    end
`endif
    sum = {1'b0, dig_a} + {1'b0, dig_b} + {4'b0, carry_q};
    if (sum > 5'd9) begin
      dig_sum = 4'(sum - 5'd10);
      c_next  = 1'b1;
    end else begin
      dig_sum = sum[3:0];
      c_next  = 1'b0;
    end
    work_next = (work_q >> 4) | (W'(dig_sum) << (W - 4));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      work_q     <= '0;
      result_q   <= '0;
      mode_q     <= 1'b0;
      carry_q    <= 1'b0;
      err_pend_q <= 1'b0;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cout_q     <= 1'b0;
      err_q      <= 1'b0;
      neg_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (bus.start) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            mode_q     <= bus.mode;
            carry_q    <= bus.mode ? ~bus.cin : bus.cin;
            err_pend_q <= err_in;
            idx_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= StCalc;
          end
        end
        StCalc: begin
          a_q     <= a_q >> 4;
          b_q     <= b_q >> 4;
          work_q  <= work_next;
          carry_q <= c_next;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LastIdx) begin
`ifdef BCD_ADDSUB_SIGN_MAG_EN
            if (mode_q && !c_next) begin
              idx_q   <= '0;
              carry_q <= 1'b1;
              state_q <= StFix;
            end else begin
              result_q <= work_next;
              cout_q   <= c_next;
              err_q    <= err_pend_q;
              neg_q    <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= StDone;
            end
`else
            result_q <= work_next;
            cout_q   <= c_next;
            err_q    <= err_pend_q;
            neg_q    <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= StDone;
`endif
          end
        end
`ifdef BCD_ADDSUB_SIGN_MAG_EN
        StFix: begin
          work_q  <= work_next;
          carry_q <= c_next;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LastIdx) begin
            result_q <= work_next;
            cout_q   <= 1'b0;
            err_q    <= err_pend_q;
            neg_q    <= 1'b1;
            done_q   <= 1'b1;
            state_q  <= StDone;
          end
        end
`endif
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.err    = err_q;
`ifdef BCD_ADDSUB_SIGN_MAG_EN
  assign bus.neg    = neg_q;
`else
  assign bus.neg    = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Self-checking bench for bcd_addsub_serial (DIGITS = 4) against an integer model.
module tb_bcd_addsub_serial;
  localparam int D = 4;
  localparam int P = 10000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  logic [15:0] last_res = 16'h0;
  bit          last_valid = 1'b1;

  bcd_addsub_serial_if #(.DIGITS(D)) bus ();

  bcd_addsub_serial #(.DIGITS(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r;
    int t = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] rand_bcd();
    logic [15:0] r;
    for (int i = 0; i < D; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // Plain decimal arithmetic on the operand values.
  task automatic model(input logic [15:0] a, b, input logic m, ci,
                       output logic [15:0] er, output logic ec, en, output int el);
    int va = bcd2int(a);
    int vb = bcd2int(b);
    int s;
    el = D;
    en = 1'b0;
    if (!m) begin
      s  = va + vb + int'(ci);
      ec = (s >= P);
      er = int2bcd(s % P);
    end else begin
      s = va - vb - int'(ci);
      if (s >= 0) begin
        ec = 1'b1;
        er = int2bcd(s);
      end else begin
        ec = 1'b0;
`ifdef BCD_ADDSUB_SIGN_MAG_EN
        er = int2bcd(-s);
        en = 1'b1;
        el = 2 * D;
`else
        er = int2bcd(s + P);
`endif
      end
    end
  endtask

  task automatic do_op(input logic [15:0] a, b, input logic m, ci,
                       input bit exp_err, input string tag);
    logic [15:0] er;
    logic ec, en;
    int el;
    int lat = 0;
    model(a, b, m, ci, er, ec, en, el);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.mode = m; bus.cin = ci; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({tag, "/busy"}, 32'(bus.busy), 32'd1);
    if (last_valid) chk({tag, "/hold"}, 32'(bus.result), 32'(last_res));
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        lat = n;
        break;
      end
    end
    chk({tag, "/latency"}, 32'(lat), 32'(el));
    if (lat != 0) begin
      if (!exp_err) begin
        chk({tag, "/result"}, 32'(bus.result), 32'(er));
        chk({tag, "/cout"}, 32'(bus.cout), 32'(ec));
        chk({tag, "/neg"}, 32'(bus.neg), 32'(en));
      end
      chk({tag, "/err"}, 32'(bus.err), 32'(exp_err));
      chk({tag, "/busy_done"}, 32'(bus.busy), 32'd1);
      @(posedge clk); #1;
      chk({tag, "/pulse"}, 32'(bus.done), 32'd0);
      chk({tag, "/idle"}, 32'(bus.busy), 32'd0);
    end
    last_res   = er;
    last_valid = !exp_err;
  endtask

  initial begin
    int cnt0, last, ndone;
    logic [15:0] ra, rb;
    bus.start = 1'b0; bus.mode = 1'b0; bus.cin = 1'b0; bus.a = '0; bus.b = '0;
    #2;
    chk("reset/outs", {26'b0, bus.busy, bus.done, bus.cout, bus.neg, bus.err, 1'b0},
        32'd0);
    chk("reset/result", 32'(bus.result), 32'd0);
    #20 rst_n = 1'b1;

    do_op(16'h5555, 16'h9999, 1'b0, 1'b0, 1'b0, "add_carry");
    do_op(16'h5555, 16'h3333, 1'b1, 1'b0, 1'b0, "sub_pos");
    do_op(16'h0100, 16'h0001, 1'b1, 1'b0, 1'b0, "sub_borrowchain");
    do_op(16'h3333, 16'h5555, 1'b1, 1'b0, 1'b0, "sub_neg");
    do_op(16'h9999, 16'h0000, 1'b0, 1'b1, 1'b0, "add_wrap");
    do_op(16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, "sub_zero_bin");
    do_op(16'h00A0, 16'h0001, 1'b0, 1'b0, 1'b1, "err_digit");
    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, "after_err");

    for (int i = 0; i < 16; i++) begin
      ra = rand_bcd();
      rb = rand_bcd();
      do_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, "random");
    end

    // start during an operation is ignored
    cnt0 = done_cnt;
    @(negedge clk);
    bus.a = 16'h1234; bus.b = 16'h1111; bus.mode = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    bus.a = 16'h9999; bus.b = 16'h9999; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("ignore/pulses", 32'(done_cnt - cnt0), 32'd1);
    chk("ignore/result", 32'(bus.result), 32'h2345);

    // start held high: one completion every DIGITS+2 cycles
    @(negedge clk);
    bus.a = 16'h0012; bus.b = 16'h0030; bus.mode = 1'b0; bus.start = 1'b1;
    last = -1;
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (last >= 0) chk("held/period", 32'(c - last), 32'(D + 2));
        last = c;
        ndone++;
      end
    end
    chk("held/count", 32'(ndone >= 4), 32'd1);
    chk("held/result", 32'(bus.result), 32'h0042);
    bus.start = 1'b0;
    repeat (8) @(posedge clk);

    // asynchronous reset mid-operation
    @(negedge clk);
    bus.a = 16'h4444; bus.b = 16'h1111; bus.mode = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    cnt0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("arst/outs", {26'b0, bus.busy, bus.done, bus.cout, bus.neg, bus.err, 1'b0},
        32'd0);
    chk("arst/result", 32'(bus.result), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("arst/nodone", 32'(done_cnt - cnt0), 32'd0);
    last_res = 16'h0;
    last_valid = 1'b1;
    do_op(16'h4444, 16'h1111, 1'b0, 1'b0, 1'b0, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/bcd_addsub_serial.md
Name: bcd_addsub_serial

Overview:
- Parametrised N-digit BCD adder/subtractor. It succeeds the fixed 2-digit combinational add/sub block.
- Processes one BCD digit per clock, least-significant digit first, through a single shared digit adder with decimal correction.
- Uses a start/busy/done handshake.
- Serves as the decimal arithmetic unit for the lab's calculator/datapath experiments, where operand width must scale without growing combinational depth.

Parameters:
- DIGITS, 4, number of BCD digits per operand/result (legal range 1..16).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- mode  input  1  0 = add, 1 = subtract
- cin  input  1  carry-in (add) / borrow-in (subtract)
- a  input  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0]
- b  input  4*DIGITS  operand B, packed BCD
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle completion pulse
- result  output  4*DIGITS  packed BCD result
- cout  output  1  add: decimal carry-out; subtract: 1 = no borrow (A >= B + cin)
- neg  output  1  result is negative magnitude (SIGN_MAG_EN only)
- err  output  1  an input digit > 9 was present in the accepted operands

Behaviour:
- Reset (asynchronous, rst_n low):
  - State goes to IDLE.
  - busy, done, result, cout, neg and err all go to 0.
  - Working registers are cleared.
  - Reset mid-operation abandons the operation; no done pulse is produced.
- States: IDLE, CALC, FIX (macro only), DONE.
- IDLE:
  - busy = 0.
  - On the edge where start = 1: latch a, b, mode, cin. Compute err = OR of (digit > 9) over all 2*DIGITS input digits. Set digit index = 0. Go to CALC.
- CALC: one digit per edge, with operand digit ad = a[i], bd = b[i] for the current index i.
  - Initial carry c0 = cin (add) or ~cin (subtract).
  - bd' = bd (add) or 9 - bd (subtract, nine's complement).
  - s = ad + bd' + c, 5 bits.
  - If s > 9: digit = s - 10, c = 1. Otherwise: digit = s, c = 0.
  - Invalid input digits are not trapped; the same arithmetic is applied to the raw 4-bit values, and err flags the condition.
  - After digit DIGITS-1, the final c becomes cout. Go to FIX if (macro enabled and mode = 1 and final c = 0), otherwise go to DONE.
- Latency:
  - start accepted at edge k; digit i is processed at edge k+1+i.
  - result, cout and err are loaded at edge k+DIGITS.
  - done is high for exactly the cycle after edge k+DIGITS (state DONE), so latency is DIGITS cycles.
- DONE:
  - done = 1, busy = 1.
  - Next edge returns to IDLE.
- Output holding: result, cout, neg and err update only on completion and hold until the next completion. They never show partial digits.
- Start handling:
  - start in CALC, FIX or DONE is ignored (not queued).
  - start held high continuously restarts on the first IDLE edge, giving back-to-back operations every DIGITS+2 cycles.
- Wrap-around:
  - Add overflow (e.g. 9999 + 0001) gives result 0000, cout = 1.
  - Subtract with borrow gives the raw ten's complement with cout = 0, unless the macro is enabled.

Optional Feature:
- Macro: BCD_ADDSUB_SIGN_MAG_EN.
- Enabled:
  - A subtraction ending with final c = 0 enters FIX.
  - FIX makes DIGITS more serial passes computing the ten's complement of the working result: per digit 9 - d, plus 1 on digit 0 with decimal carry propagation.
  - Then DONE, with neg = 1, cout = 0 and result = |A - B - cin|. Latency in this case is 2*DIGITS.
  - neg = 0 for all other operations.
- Disabled:
  - The FIX state and its logic are absent.
  - neg is tied to 0.
  - result is the raw ten's complement.

Test Plan (DIGITS = 4, cin = 0 unless stated):
- a=0x5555, b=0x9999, mode=0 -> result=0x5554, cout=1, err=0; done exactly 4 cycles after start edge, single-cycle pulse.
- a=0x5555, b=0x3333, mode=1 -> result=0x2222, cout=1, neg=0; a=0x0100, b=0x0001, mode=1 -> result=0x0099, cout=1.
- a=0x3333, b=0x5555, mode=1 -> macro off: result=0x7778, cout=0, neg=0, latency 4; macro on: result=0x2222, cout=0, neg=1, latency 8.
- a=0x9999, b=0x0000, mode=0, cin=1 -> result=0x0000, cout=1; a=0x00A0, b=0x0001, mode=0 -> err=1, done still pulses after 4 cycles.
- Pulse start again 2 cycles into an operation -> ignored, single done pulse, result of first operands; start held high -> done pulses every 6 cycles.
- Assert rst_n=0 at cycle 2 of an operation -> all outputs 0 immediately (asynchronous), no done pulse; a new start after release completes correctly.
